// File: rtl/ds1302_burst_ctrlmod.sv
`default_nettype none
// ds1302_burst_ctrlmod - sequences a multi-register DS1302 access as byte-level
// command transactions, optionally wrapped in write-protect clear/set.  Rev 1.0
module ds1302_burst_ctrlmod #(
   parameter int NREG    = 7,
   parameter int AUTO_WP = 1,
   parameter int TIMEOUT = 1023
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              iCall,
   input  logic              iWrite,
   input  logic [2:0]        iIndex,
   input  logic [2:0]        iCount,
   input  logic [8*NREG-1:0] iWrData,
   output logic              oDone,
   output logic              oErr,
   output logic [8*NREG-1:0] oRdData,
   output logic [1:0]        oCall,
   input  logic              iDone,
   input  logic [7:0]        iData,
   output logic [7:0]        oAddr,
   output logic [7:0]        oData
);
   localparam int             TW      = $clog2(TIMEOUT);
   localparam logic [TW-1:0]  TLAST   = TW'(TIMEOUT - 1);
   localparam logic           USE_WP  = (AUTO_WP != 0);
   localparam logic [3:0]     NREG4   = 4'(NREG);
   localparam logic [7:0]     WP_ADDR = 8'h8E;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_UNPROT  = 3'd1,
      S_XFER    = 3'd2,
      S_GAP     = 3'd3,
      S_PROT    = 3'd4,
      S_DONE    = 3'd5,
      S_RELEASE = 3'd6
   } state_t;

   state_t            state_q, gapnxt_q;
   logic              wr_q, err_q, done_q, oerr_q;
   logic [2:0]        idx_q, last_q;
   logic [8*NREG-1:0] wdata_q, rdata_q;
   logic [1:0]        call_q;
   logic [7:0]        addr_q, data_q;
   logic [TW-1:0]     tcnt_q;

   logic [3:0] end_sum;
   logic [7:0] sel_byte;
   logic       wrap;
   state_t     ok_state, ok_gap, to_state;
   logic       ok_inc;

   assign end_sum = {1'b0, iIndex} + {1'b0, iCount};
   assign wrap    = wr_q && USE_WP;

   always_comb begin
      sel_byte = 8'h00;
      for (int k = 0; k < NREG; k++) begin
         if (idx_q == 3'(k)) sel_byte = wdata_q[8*k +: 8];
      end
   end

   // Where a transaction hands off to on a normal completion versus a timeout.
   always_comb begin
      ok_state = S_DONE;
      ok_gap   = S_XFER;
      ok_inc   = 1'b0;
      case (state_q)
         S_UNPROT: ok_state = S_GAP;
         S_XFER: begin
            if (idx_q != last_q) begin
               ok_state = S_GAP;
               ok_inc   = 1'b1;
            end else if (wrap) begin
               ok_state = S_GAP;
               ok_gap   = S_PROT;
            end
         end
         default: ;
      endcase
      to_state = (wrap && state_q != S_PROT) ? S_GAP : S_DONE;
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         gapnxt_q <= S_IDLE;
         wr_q     <= 1'b0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         oerr_q   <= 1'b0;
         idx_q    <= 3'd0;
         last_q   <= 3'd0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         call_q   <= 2'b00;
         addr_q   <= 8'h00;
         data_q   <= 8'h00;
         tcnt_q   <= '0;
      end else begin
         done_q <= 1'b0;
         oerr_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (iCall) begin
                  wr_q    <= iWrite;
                  idx_q   <= iIndex;
                  last_q  <= end_sum[2:0];
                  wdata_q <= iWrData;
                  err_q   <= 1'b0;
                  if (end_sum >= NREG4) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     oerr_q  <= 1'b1;
                  end else if (iWrite && USE_WP) begin
                     state_q <= S_UNPROT;
                  end else begin
                     state_q <= S_XFER;
                  end
               end
            end
            S_UNPROT, S_XFER, S_PROT: begin
               if (call_q == 2'b00) begin
                  tcnt_q <= '0;
                  call_q <= (state_q == S_XFER && !wr_q) ? 2'b01 : 2'b10;
                  addr_q <= (state_q == S_XFER) ? {4'b1000, idx_q, ~wr_q} : WP_ADDR;
                  if (state_q == S_XFER)      data_q <= wr_q ? sel_byte : 8'h00;
                  else if (state_q == S_PROT) data_q <= 8'h80;
                  else                        data_q <= 8'h00;
               end else if (iDone) begin
                  call_q   <= 2'b00;
                  state_q  <= ok_state;
                  gapnxt_q <= ok_gap;
                  if (ok_inc) idx_q <= idx_q + 3'd1;
                  if (call_q[0]) begin
                     for (int k = 0; k < NREG; k++) begin
                        if (idx_q == 3'(k)) rdata_q[8*k +: 8] <= iData;
                     end
                  end
                  if (ok_state == S_DONE) begin
                     done_q <= 1'b1;
                     oerr_q <= err_q;
                  end
               end else if (tcnt_q == TLAST) begin
                  call_q   <= 2'b00;
                  err_q    <= 1'b1;
                  state_q  <= to_state;
                  gapnxt_q <= S_PROT;
                  if (to_state == S_DONE) begin
                     done_q <= 1'b1;
                     oerr_q <= 1'b1;
                  end
               end else begin
                  tcnt_q <= tcnt_q + 1'b1;
               end
            end
            S_GAP:     state_q <= gapnxt_q;
            S_DONE:    state_q <= S_RELEASE;
            S_RELEASE: if (!iCall) state_q <= S_IDLE;
            default:   state_q <= S_IDLE;
         endcase
      end
   end

   assign oDone   = done_q;
   assign oErr    = oerr_q;
   assign oRdData = rdata_q;
   assign oCall   = call_q;
   assign oAddr   = addr_q;
   assign oData   = data_q;

endmodule
`default_nettype wire

// File: doc/ds1302_burst_ctrlmod.md
DS1302_BURST_CTRLMOD -- requirements
Module: ds1302_burst_ctrlmod

Interface
REQ-001 Parameter NREG, default 7, number of addressable RTC registers (legal 1..7; register k command byte = 8'h80 | k<<1 | rd).
REQ-002 Parameter AUTO_WP, default 1; 1 = wrap every write request in unprotect/protect transactions.
REQ-003 Parameter TIMEOUT, default 1023, max cycles oCall may stay high without iDone (legal >= 2).
REQ-004 CLOCK  in  1  sole clock; all state changes on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 iCall  in  1  request; held high by caller until oDone.
REQ-007 iWrite  in  1  1 = write request, 0 = read request; sampled with iCall.
REQ-008 iIndex  in  3  first register index.
REQ-009 iCount  in  3  number of registers minus one.
REQ-010 iWrData  in  8*NREG  write bytes; register k at bits [8k+7:8k].
REQ-011 oDone  out  1  one-cycle completion pulse.
REQ-012 oErr  out  1  error flag, valid only while oDone high.
REQ-013 oRdData  out  8*NREG  captured read bytes, same packing as iWrData.
REQ-014 oCall  out  2  byte-level request: [1] write transaction, [0] read transaction.
REQ-015 iDone  in  1  byte-level completion pulse.
REQ-016 iData  in  8  byte-level read data, valid with iDone.
REQ-017 oAddr  out  8  command byte to byte-level layer.
REQ-018 oData  out  8  write byte to byte-level layer.

Function
REQ-019 States SHALL be IDLE, UNPROT, XFER, GAP, PROT, DONE, RELEASE.
REQ-020 IDLE: iCall high at an edge latches iWrite/iIndex/iCount/iWrData; next state UNPROT if iWrite & AUTO_WP, else XFER.
REQ-021 Range check at acceptance: iIndex+iCount >= NREG -> DONE with oErr=1, no oCall activity.
REQ-022 UNPROT: oCall[1]=1, oAddr=8'h8E, oData=8'h00; PROT: oCall[1]=1, oAddr=8'h8E, oData=8'h80.
REQ-023 XFER for register k: write -> oCall[1]=1, oAddr=8'h80|k<<1, oData=latched byte k; read -> oCall[0]=1, oAddr=8'h81|k<<1, oData=8'h00.
REQ-024 oCall rises the cycle after entering a transaction state; oAddr/oData stable whenever oCall nonzero; oCall never 2'b11.
REQ-025 iDone high at an edge while oCall nonzero: oCall cleared that edge; on read, iData stored into oRdData byte k.
REQ-026 After each iDone the block SHALL spend exactly one cycle in GAP (oCall=0) before the next transaction.
REQ-027 Sequence order: UNPROT (if applicable), registers iIndex..iIndex+iCount ascending, PROT (if applicable), DONE.
REQ-028 iDone while oCall=0 SHALL be ignored.
REQ-029 Timeout counter clears at each transaction start; reaching TIMEOUT drops oCall, sets sticky error.
REQ-030 Timeout in UNPROT or XFER of an AUTO_WP write -> GAP then PROT; timeout elsewhere (or PROT) -> DONE.
REQ-031 DONE: oDone=1 one cycle, oErr=sticky error; next state RELEASE.
REQ-032 RELEASE: remain until iCall sampled low, then IDLE; no new request accepted before.
REQ-033 oRdData bytes outside the requested range SHALL retain prior values.
REQ-034 Latency, 1-register read, iDone returned N cycles after oCall rise: oDone high exactly 1 cycle after the iDone cycle.

Reset
REQ-035 RESET high at an edge: state IDLE, oCall=0, oDone=0, oErr=0, oAddr=0, oData=0, oRdData=0, error and counters cleared; takes priority over all other inputs, including mid-transaction.

Verification
REQ-036 Read iIndex=0,iCount=2, model returns 8'h59,8'h30,8'h12 -> oAddr 81,83,85 with 1-cycle gaps; oRdData[23:0]=24'h123059; oDone one pulse, oErr=0.
REQ-037 Write iIndex=1,iCount=1, iWrData bytes 1,2 = 8'h45,8'h09, AUTO_WP=1 -> writes (8E,00),(82,45),(84,09),(8E,80) in order; oCall[0] never high.
REQ-038 iIndex=6,iCount=1, NREG=7 -> oDone with oErr=1 within 3 cycles, oCall stays 0.
REQ-039 Write, model withholds iDone on 2nd transaction, TIMEOUT=16 -> oCall drops after 16 cycles, PROT (8E,80) issued, oDone with oErr=1.
REQ-040 RESET asserted while oCall[0]=1 mid-burst -> next cycle oCall=0, oRdData=0; iCall held high afterwards starts a fresh sequence.
REQ-041 iCall held high past oDone -> no second sequence until iCall low one cycle; spurious iDone in GAP/IDLE has no effect.
